// File: rtl/mc_ctrl_fsm.sv
// Multicycle MIPS main control FSM.
// Sequences each instruction through fetch/decode/execute/memory/writeback,
// with a memory ready handshake, a wait-state watchdog and illegal-opcode
// detection.
// Optional feature: define EXT_OPS_EN to add BNE (BRANCHNE) and ORI (ORIEX).
module mc_ctrl_fsm #(
    parameter int WAIT_TIMEOUT = 15,
    parameter int CNT_W        = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] op,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       iord,
    output logic       mem_write,
    output logic       ir_write,
    output logic       pc_write,
    output logic       branch,
    output logic       branch_ne,
    output logic [1:0] pc_src,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       reg_dest,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       illegal_op,
    output logic       bus_error,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEX   = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JUMP     = 4'd11,
        S_BRANCHNE = 4'd12,
        S_ORIEX    = 4'd13
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
`ifdef EXT_OPS_EN
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ORI   = 6'b001101;
`endif

    localparam bit             WD_EN       = (WAIT_TIMEOUT != 0);
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(WAIT_TIMEOUT);

    state_t           cur;
    logic [CNT_W-1:0] wait_cnt;
    logic             in_wait;
    logic             timeout;
    logic             op_legal;
    state_t           decode_next;

    // Wait-state detection and watchdog abort condition; completion wins over timeout.
    always_comb begin
        in_wait = (cur == S_FETCH) || (cur == S_MEMRD) || (cur == S_MEMWR);
        timeout = WD_EN && in_wait && !mem_ready && (wait_cnt == TIMEOUT_CNT);
    end

    // Opcode dispatch out of DECODE; unknown opcodes fall back to FETCH.
    always_comb begin
        decode_next = S_FETCH;
        op_legal    = 1'b1;
        case (op)
            OP_LW, OP_SW: decode_next = S_MEMADR;
            OP_RTYPE:     decode_next = S_EXECUTE;
            OP_BEQ:       decode_next = S_BRANCH;
            OP_ADDI:      decode_next = S_ADDIEX;
            OP_J:         decode_next = S_JUMP;
`ifdef EXT_OPS_EN
            OP_BNE:       decode_next = S_BRANCHNE;
            OP_ORI:       decode_next = S_ORIEX;
`endif
            default:      op_legal    = 1'b0;
        endcase
    end

    // State register and wait counter; the counter clears whenever the state changes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cur      <= S_FETCH;
            wait_cnt <= '0;
        end else if (in_wait && !mem_ready) begin
            if (timeout) begin
                cur      <= S_FETCH;
                wait_cnt <= '0;
            end else if (wait_cnt != '1) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
        end else begin
            wait_cnt <= '0;
            case (cur)
                S_FETCH:   cur <= S_DECODE;
                S_DECODE:  cur <= decode_next;
                S_MEMADR:  cur <= (op == OP_SW) ? S_MEMWR : S_MEMRD;
                S_MEMRD:   cur <= S_MEMWB;
                S_EXECUTE: cur <= S_ALUWB;
                S_ADDIEX:  cur <= S_ADDIWB;
                S_ORIEX:   cur <= S_ADDIWB;
                default:   cur <= S_FETCH;
            endcase
        end
    end

    // Control decode from state; FETCH writes and the decode/abort pulses need same-cycle inputs.
    always_comb begin
        mem_req    = 1'b0;
        iord       = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        branch     = 1'b0;
        branch_ne  = 1'b0;
        pc_src     = 2'b00;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        reg_dest   = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        case (cur)
            S_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE: alu_src_b = 2'b11;
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEMRD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                mem_req   = 1'b1;
                iord      = 1'b1;
                mem_write = 1'b1;
            end
            S_EXECUTE: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                reg_dest  = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b01;
                pc_src    = 2'b01;
                branch    = 1'b1;
            end
            S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_ADDIWB: reg_write = 1'b1;
            S_JUMP: begin
                pc_src   = 2'b10;
                pc_write = 1'b1;
            end
`ifdef EXT_OPS_EN
            S_BRANCHNE: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b01;
                pc_src    = 2'b01;
                branch_ne = 1'b1;
            end
            S_ORIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_op    = 2'b11;
            end
`endif
            default: ;
        endcase
        illegal_op = (cur == S_DECODE) && !op_legal;
        bus_error  = timeout;
    end

    assign state = cur;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Self-checking bench for mc_ctrl_fsm: instruction-level reference model plus
// directed literal checks, followed by randomized opcodes, ready and resets.
module tb_mc_ctrl_fsm;

    localparam int TO = 15;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ORI   = 6'b001101;

    typedef struct packed {
        logic       mem_req;
        logic       iord;
        logic       mem_write;
        logic       ir_write;
        logic       pc_write;
        logic       branch;
        logic       branch_ne;
        logic [1:0] pc_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       reg_dest;
        logic       mem_to_reg;
        logic       reg_write;
        logic       illegal_op;
        logic       bus_error;
    } ctrl_t;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [5:0] op;
    logic       mem_ready;
    logic       mem_req, iord, mem_write, ir_write, pc_write, branch, branch_ne;
    logic [1:0] pc_src, alu_src_b, alu_op;
    logic       alu_src_a, reg_dest, mem_to_reg, reg_write, illegal_op, bus_error;
    logic [3:0] state;

    int n_checks = 0;
    int n_errors = 0;

    // model: step index inside current instruction, latched opcode, wait count
    int         m_phase = 0;
    logic [5:0] m_iop   = 6'b0;
    int         m_wait  = 0;

    mc_ctrl_fsm #(.WAIT_TIMEOUT(TO), .CNT_W(4)) dut (
        .clk(clk), .reset_n(reset_n), .op(op), .mem_ready(mem_ready),
        .mem_req(mem_req), .iord(iord), .mem_write(mem_write),
        .ir_write(ir_write), .pc_write(pc_write), .branch(branch),
        .branch_ne(branch_ne), .pc_src(pc_src), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .reg_dest(reg_dest),
        .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .illegal_op(illegal_op), .bus_error(bus_error), .state(state)
    );

    always #5 clk = ~clk;

    // total cycles an instruction takes with no wait states; 2 means illegal
    function automatic int op_len(input logic [5:0] o);
        if (o == OP_LW) return 5;
        if (o == OP_SW || o == OP_RTYPE || o == OP_ADDI) return 4;
        if (o == OP_BEQ || o == OP_J) return 3;
`ifdef EXT_OPS_EN
        if (o == OP_BNE) return 3;
        if (o == OP_ORI) return 4;
`endif
        return 2;
    endfunction

    function automatic string step_of(input int ph, input logic [5:0] o);
        if (ph == 0) return "FETCH";
        if (ph == 1) return "DECODE";
        if (o == OP_LW)    return (ph == 2) ? "MEMADR" : (ph == 3) ? "MEMRD" : "MEMWB";
        if (o == OP_SW)    return (ph == 2) ? "MEMADR" : "MEMWR";
        if (o == OP_RTYPE) return (ph == 2) ? "EXECUTE" : "ALUWB";
        if (o == OP_BEQ)   return "BRANCH";
        if (o == OP_ADDI)  return (ph == 2) ? "ADDIEX" : "ADDIWB";
        if (o == OP_J)     return "JUMP";
        if (o == OP_BNE)   return "BRANCHNE";
        return (ph == 2) ? "ORIEX" : "ADDIWB";
    endfunction

    function automatic bit is_wait(input string s);
        return (s == "FETCH") || (s == "MEMRD") || (s == "MEMWR");
    endfunction

    function automatic ctrl_t model_expect(input string s, input logic rdy,
                                           input logic [5:0] live_op, input int wc);
        ctrl_t e;
        e = '0;
        if (s == "FETCH") begin
            e.mem_req = 1'b1; e.alu_src_b = 2'b01; e.ir_write = rdy; e.pc_write = rdy;
        end else if (s == "DECODE") begin
            e.alu_src_b = 2'b11; e.illegal_op = (op_len(live_op) == 2);
        end else if (s == "MEMADR" || s == "ADDIEX") begin
            e.alu_src_a = 1'b1; e.alu_src_b = 2'b10;
        end else if (s == "MEMRD") begin
            e.mem_req = 1'b1; e.iord = 1'b1;
        end else if (s == "MEMWB") begin
            e.reg_write = 1'b1; e.mem_to_reg = 1'b1;
        end else if (s == "MEMWR") begin
            e.mem_req = 1'b1; e.iord = 1'b1; e.mem_write = 1'b1;
        end else if (s == "EXECUTE") begin
            e.alu_src_a = 1'b1; e.alu_op = 2'b10;
        end else if (s == "ALUWB") begin
            e.reg_write = 1'b1; e.reg_dest = 1'b1;
        end else if (s == "BRANCH") begin
            e.alu_src_a = 1'b1; e.alu_op = 2'b01; e.pc_src = 2'b01; e.branch = 1'b1;
        end else if (s == "BRANCHNE") begin
            e.alu_src_a = 1'b1; e.alu_op = 2'b01; e.pc_src = 2'b01; e.branch_ne = 1'b1;
        end else if (s == "ORIEX") begin
            e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; e.alu_op = 2'b11;
        end else if (s == "ADDIWB") begin
            e.reg_write = 1'b1;
        end else if (s == "JUMP") begin
            e.pc_src = 2'b10; e.pc_write = 1'b1;
        end
        e.bus_error = is_wait(s) && !rdy && (TO != 0) && (wc == TO);
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic [5:0] o, input logic rdy);
        @(posedge clk);
        #1;
        op        = o;
        mem_ready = rdy;
    endtask

    task automatic runCycle(input logic [5:0] o, input logic rdy);
        applyStimulus(o, rdy);
        @(negedge clk);
    endtask

    // Per-cycle comparison of the DUT against the instruction-level model, then model advance.
    always @(negedge clk) begin : model_cmp
        string s;
        ctrl_t exp_c;
        ctrl_t act_c;
        if (!reset_n) begin
            m_phase = 0;
            m_wait  = 0;
        end
        s     = step_of(m_phase, m_iop);
        exp_c = model_expect(s, mem_ready, op, m_wait);
        act_c = {mem_req, iord, mem_write, ir_write, pc_write, branch, branch_ne,
                 pc_src, alu_src_a, alu_src_b, alu_op, reg_dest, mem_to_reg,
                 reg_write, illegal_op, bus_error};
        checkOutput({"ctrl_", s}, 32'(act_c), 32'(exp_c));
        checkOutput("state_is_fetch", 32'(state == 4'd0), 32'(m_phase == 0));
        if (reset_n) begin
            if (is_wait(s) && !mem_ready) begin
                if (TO != 0 && m_wait == TO) begin
                    m_phase = 0;
                    m_wait  = 0;
                end else begin
                    m_wait++;
                end
            end else begin
                m_wait = 0;
                if (m_phase == 1) begin
                    m_iop   = op;
                    m_phase = (op_len(op) > 2) ? 2 : 0;
                end else begin
                    m_phase++;
                    if (m_phase >= op_len(m_iop)) m_phase = 0;
                end
            end
        end
    end

    function automatic logic [5:0] pick_op();
        logic [5:0] tbl [8];
        tbl = '{OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J, OP_BNE, OP_ORI};
        if ($urandom_range(0, 7) == 0) return 6'($urandom_range(0, 63));
        return tbl[$urandom_range(0, 7)];
    endfunction

    initial begin
        bit stall;
        reset_n   = 1'b0;
        op        = OP_RTYPE;
        mem_ready = 1'b0;
        stall     = 1'b0;

        // reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_state", 32'(state), 32'd0);
        checkOutput("rst_mem_req", 32'(mem_req), 32'd1);
        checkOutput("rst_iord", 32'(iord), 32'd0);
        checkOutput("rst_alu_src_b", 32'(alu_src_b), 32'd1);
        checkOutput("rst_illegal", 32'(illegal_op), 32'd0);
        checkOutput("rst_bus_error", 32'(bus_error), 32'd0);
        @(posedge clk);
        #1 reset_n = 1'b1;

        // LW, no wait states: 5 cycles
        runCycle(OP_LW, 1'b1);
        checkOutput("lw_c1_state", 32'(state), 32'd0);
        checkOutput("lw_c1_ir_write", 32'(ir_write), 32'd1);
        checkOutput("lw_c1_pc_write", 32'(pc_write), 32'd1);
        runCycle(OP_LW, 1'b1);
        checkOutput("lw_c2_alu_src_b", 32'(alu_src_b), 32'd3);
        runCycle(OP_LW, 1'b1);
        checkOutput("lw_c3_alu_src_a", 32'(alu_src_a), 32'd1);
        checkOutput("lw_c3_alu_src_b", 32'(alu_src_b), 32'd2);
        runCycle(OP_LW, 1'b1);
        checkOutput("lw_c4_iord", 32'(iord), 32'd1);
        runCycle(OP_LW, 1'b1);
        checkOutput("lw_c5_reg_write", 32'(reg_write), 32'd1);
        checkOutput("lw_c5_mem_to_reg", 32'(mem_to_reg), 32'd1);

        // R-type then BEQ
        runCycle(OP_RTYPE, 1'b1);
        checkOutput("lw_c6_state", 32'(state), 32'd0);
        runCycle(OP_RTYPE, 1'b1);
        runCycle(OP_RTYPE, 1'b1);
        checkOutput("ex_alu_op", 32'(alu_op), 32'd2);
        runCycle(OP_RTYPE, 1'b1);
        checkOutput("aluwb_reg_dest", 32'(reg_dest), 32'd1);
        checkOutput("aluwb_reg_write", 32'(reg_write), 32'd1);
        runCycle(OP_BEQ, 1'b1);
        checkOutput("r_done_state", 32'(state), 32'd0);
        runCycle(OP_BEQ, 1'b1);
        runCycle(OP_BEQ, 1'b1);
        checkOutput("beq_branch", 32'(branch), 32'd1);
        checkOutput("beq_pc_src", 32'(pc_src), 32'd1);
        checkOutput("beq_alu_op", 32'(alu_op), 32'd1);

        // SW with three wait cycles in MEMWR
        runCycle(OP_SW, 1'b1);
        checkOutput("beq_done_state", 32'(state), 32'd0);
        runCycle(OP_SW, 1'b1);
        runCycle(OP_SW, 1'b1);
        for (int i = 0; i < 3; i++) begin
            runCycle(OP_SW, 1'b0);
            checkOutput("sw_wait_mem_write", 32'(mem_write), 32'd1);
            checkOutput("sw_wait_bus_error", 32'(bus_error), 32'd0);
        end
        runCycle(OP_SW, 1'b1);
        checkOutput("sw_last_mem_write", 32'(mem_write), 32'd1);

        // watchdog in FETCH: abort on the 16th wait cycle, twice
        for (int i = 1; i <= 32; i++) begin
            runCycle(OP_RTYPE, 1'b0);
            if (i == 1) checkOutput("sw_done_state", 32'(state), 32'd0);
            checkOutput("to_pc_write", 32'(pc_write), 32'd0);
            checkOutput("to_bus_error", 32'(bus_error), 32'((i == 16) || (i == 32)));
        end

        // ready arriving on the timeout cycle completes the fetch; then J
        for (int i = 0; i < 15; i++) runCycle(OP_J, 1'b0);
        runCycle(OP_J, 1'b1);
        checkOutput("race_bus_error", 32'(bus_error), 32'd0);
        checkOutput("race_ir_write", 32'(ir_write), 32'd1);
        runCycle(OP_J, 1'b0);
        runCycle(OP_J, 1'b0);
        checkOutput("j_pc_write", 32'(pc_write), 32'd1);
        checkOutput("j_pc_src", 32'(pc_src), 32'd2);

        // ORI: extension or illegal
        runCycle(OP_ORI, 1'b1);
        checkOutput("j_done_state", 32'(state), 32'd0);
        runCycle(OP_ORI, 1'b1);
`ifdef EXT_OPS_EN
        checkOutput("ori_illegal", 32'(illegal_op), 32'd0);
        runCycle(OP_ORI, 1'b1);
        checkOutput("oriex_alu_op", 32'(alu_op), 32'd3);
        runCycle(OP_ORI, 1'b1);
        checkOutput("ori_wb_reg_write", 32'(reg_write), 32'd1);
`else
        checkOutput("ori_illegal", 32'(illegal_op), 32'd1);
        runCycle(OP_ORI, 1'b0);
        checkOutput("ori_back_fetch", 32'(state), 32'd0);
`endif

        // reset in the middle of a stalled MEMRD
        runCycle(OP_LW, 1'b1);
        runCycle(OP_LW, 1'b1);
        runCycle(OP_LW, 1'b1);
        runCycle(OP_LW, 1'b0);
        runCycle(OP_LW, 1'b0);
        checkOutput("memrd_iord", 32'(iord), 32'd1);
        @(posedge clk);
        #1 reset_n = 1'b0;
        @(negedge clk);
        checkOutput("midrst_state", 32'(state), 32'd0);
        checkOutput("midrst_mem_req", 32'(mem_req), 32'd1);
        checkOutput("midrst_iord", 32'(iord), 32'd0);
        checkOutput("midrst_alu_src_b", 32'(alu_src_b), 32'd1);
        checkOutput("midrst_reg_write", 32'(reg_write), 32'd0);
        checkOutput("midrst_flags", 32'({illegal_op, bus_error}), 32'd0);
        @(posedge clk);
        #1 reset_n = 1'b1;

        // randomized traffic checked by the model
        for (int c = 0; c < 4000; c++) begin
            @(posedge clk);
            #1;
            if (!reset_n) reset_n = 1'b1;
            else if ($urandom_range(0, 599) == 0) reset_n = 1'b0;
            if (c % 97 == 0) stall = ($urandom_range(0, 3) == 0);
            if (m_phase == 0 && $urandom_range(0, 2) == 0) op = pick_op();
            mem_ready = stall ? 1'b0 : ($urandom_range(0, 9) < 6);
        end
        @(posedge clk);
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
